f_pc_unit: RTL and testbench

//  Parametrised fetch-PC generator: owns the F-stage PC register and computes the next PC from

---
 rtl/f_pc_unit.sv | 119 +++++++++++
 tb/tb_f_pc_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_pc_unit.sv
// Fetch-stage PC generator. Selects the next PC from exception, eret, stall and D-stage
// redirect, flags F-stage address errors, and keeps a return-address stack for jr $ra.
module f_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter bit          ERET_PLUS4 = 1'b1,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES   = 32'h0000_4000,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             req,
  input  logic             eret,
  input  logic [31:0]      epc,
  input  logic [2:0]       npc_op,
  input  logic [31:0]      d_pc,
  input  logic             b_jump,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      rs,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [31:0]      f_pc,
  output logic             f_adel,
  output logic [31:0]      ras_top,
  output logic             ras_valid,
  output logic [CNT_W-1:0] ras_miss_cnt
);

  typedef enum logic [2:0] {
    NPC_PC4     = 3'd0,
    NPC_B       = 3'd1,
    NPC_J_JAL   = 3'd2,
    NPC_JR_JALR = 3'd3
  } npc_op_e;

  localparam int unsigned SP_W   = $clog2(RAS_DEPTH);
  localparam int unsigned CT_W   = SP_W + 1;
  // 33-bit end address so a window reaching the top of the address space cannot wrap
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  npc_op_e          op;
  logic [31:0]      pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [CT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [31:0]      ras_q [RAS_DEPTH];
  logic             ras_we;
  logic [SP_W-1:0]  ras_widx;
  logic [31:0]      ras_wdata;
  logic [31:0]      br_off;
  logic             upd, push_g, pop_g;

  assign op     = npc_op_e'(npc_op);
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (req)                          pc_d = EXC_VEC;
    else if (eret)                    pc_d = epc + (ERET_PLUS4 ? 32'd4 : 32'd0);
    else if (stall)                   pc_d = pc_q;
    else if (op == NPC_JR_JALR)       pc_d = rs;
    else if (op == NPC_B && b_jump)   pc_d = d_pc + 32'd4 + br_off;
    else if (op == NPC_J_JAL)         pc_d = {d_pc[31:28], imm26, 2'b00};
  end

  assign upd    = !stall && !req && !eret;
  assign push_g = upd && ras_push;
  assign pop_g  = upd && ras_pop;

  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_widx  = sp_q + 1'b1;
    ras_wdata = d_pc + 32'd8;
    miss_d    = miss_q;
    // call+return in one instruction replaces the top; on an empty stack it is a plain push
    if (push_g && pop_g && cnt_q != '0) begin
      ras_we   = 1'b1;
      ras_widx = sp_q;
    end else if (push_g) begin
      ras_we = 1'b1;
      sp_d   = sp_q + 1'b1;
      if (cnt_q != CT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop_g && cnt_q != '0) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (pop_g && op == NPC_JR_JALR && (cnt_q == '0 || rs != ras_q[sp_q]) && miss_q != '1)
      miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      sp_q   <= '0;
      cnt_q  <= '0;
      miss_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      if (ras_we) ras_q[ras_widx] <= ras_wdata;
    end
  end

  assign f_pc         = pc_q;
  assign f_adel       = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);
  assign ras_top      = ras_q[sp_q];
  assign ras_valid    = (cnt_q != '0);
  assign ras_miss_cnt = miss_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: vector table, hand sequences for the RAS corners, and a random run
// against a queue-based reference model.
module tb_f_pc_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned MAXC  = 63;
  localparam logic [2:0] OP_PC4 = 3'd0, OP_B = 3'd1, OP_J = 3'd2, OP_JR = 3'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall, req, eret, b_jump, ras_push, ras_pop;
  logic [31:0] epc, d_pc, rs;
  logic [2:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] f_pc, ras_top;
  logic        f_adel, ras_valid;
  logic [CNT_W-1:0] ras_miss_cnt;

  always #5 clk = ~clk;

  f_pc_unit #(
    .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .ERET_PLUS4(1'b1),
    .IM_BASE(32'h0000_3000), .IM_BYTES(32'h0000_4000), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .npc_op(npc_op), .d_pc(d_pc), .b_jump(b_jump), .imm16(imm16), .imm26(imm26), .rs(rs),
    .ras_push(ras_push), .ras_pop(ras_pop), .f_pc(f_pc), .f_adel(f_adel), .ras_top(ras_top),
    .ras_valid(ras_valid), .ras_miss_cnt(ras_miss_cnt)
  );

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model: fetch PC, RAS as a bounded list of return addresses, miss count
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int unsigned m_miss;

  function automatic bit exp_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc >= 32'h7000);
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000;
    m_ras.delete();
    m_miss = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/f_pc"}, f_pc, m_pc);
    chk({tag, "/f_adel"}, {31'd0, f_adel}, {31'd0, exp_adel(m_pc)});
    chk({tag, "/ras_valid"}, {31'd0, ras_valid}, {31'd0, m_ras.size() != 0});
    chk({tag, "/miss"}, {26'd0, ras_miss_cnt}, m_miss);
    if (m_ras.size() != 0) chk({tag, "/ras_top"}, ras_top, m_ras[$]);
  endtask

  task automatic step(input string tag);
    logic [31:0] npc;
    bit gate;
    if (req)                        npc = 32'h4180;
    else if (eret)                  npc = epc + 32'd4;
    else if (stall)                 npc = m_pc;
    else if (npc_op == OP_JR)       npc = rs;
    else if (npc_op == OP_B && b_jump) npc = d_pc + 32'd4 + 32'($signed(imm16) * 4);
    else if (npc_op == OP_J)        npc = (d_pc & 32'hF000_0000) | (32'(imm26) * 4);
    else                            npc = m_pc + 32'd4;
    gate = !stall && !req && !eret;
    if (gate && ras_pop && npc_op == OP_JR && (m_ras.size() == 0 || rs != m_ras[$]) && m_miss < MAXC)
      m_miss++;
    if (gate && ras_push && ras_pop && m_ras.size() != 0) begin
      m_ras[m_ras.size()-1] = d_pc + 32'd8;
    end else if (gate && ras_push) begin
      m_ras.push_back(d_pc + 32'd8);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (gate && ras_pop && m_ras.size() != 0) begin
      void'(m_ras.pop_back());
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    stall = 0; req = 0; eret = 0; b_jump = 0; ras_push = 0; ras_pop = 0;
    epc = '0; d_pc = 32'h3000; rs = '0; npc_op = OP_PC4; imm16 = '0; imm26 = '0;
  endtask

  task automatic do_reset(input string tag);
    idle();
    reset = 0;
    #1;
    model_reset();
    chk({tag, "/rst_pc"}, f_pc, 32'h3000);
    chk({tag, "/rst_valid"}, {31'd0, ras_valid}, 32'd0);
    chk({tag, "/rst_miss"}, {26'd0, ras_miss_cnt}, 32'd0);
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    bit          req, eret, stall, bj;
    logic [2:0]  op;
    logic [31:0] dpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs, epc, exp_pc;
    bit          exp_adel;
  } vec_t;

  vec_t vt[$];

  initial begin
    //          req eret stall bj op      dpc           i16       i26          rs            epc           exp_pc        adel
    vt.push_back('{0, 0, 0, 0, OP_PC4, 32'h3000, 16'h0000, 26'h0, 32'h0, 32'h0, 32'h3004, 0});
    vt.push_back('{0, 0, 0, 0, OP_PC4, 32'h3000, 16'h0000, 26'h0, 32'h0, 32'h0, 32'h3008, 0});
    vt.push_back('{0, 0, 0, 1, OP_B,   32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h0, 32'h3004, 0});
    vt.push_back('{0, 0, 0, 0, OP_B,   32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h0, 32'h3008, 0});
    vt.push_back('{0, 0, 1, 0, OP_J,   32'h3000, 16'h0000, 26'hC40, 32'h0, 32'h0, 32'h3008, 0});
    vt.push_back('{1, 0, 1, 0, OP_J,   32'h3000, 16'h0000, 26'hC40, 32'h0, 32'h0, 32'h4180, 0});
    vt.push_back('{0, 1, 1, 0, OP_PC4, 32'h3000, 16'h0000, 26'h0, 32'h0, 32'h3020, 32'h3024, 0});
    vt.push_back('{0, 0, 0, 0, OP_J,   32'h3000, 16'h0000, 26'hC40, 32'h0, 32'h0, 32'h3100, 0});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h3002, 32'h0, 32'h3002, 1});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h7000, 32'h0, 32'h7000, 1});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h6FFC, 32'h0, 32'h6FFC, 0});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h2FFC, 32'h0, 32'h2FFC, 1});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 1});
    vt.push_back('{0, 0, 0, 0, OP_PC4, 32'h3000, 16'h0000, 26'h0, 32'h0, 32'h0, 32'h0000, 1});
    vt.push_back('{1, 1, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h5000, 32'h3100, 32'h4180, 0});
    vt.push_back('{0, 1, 1, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h5000, 32'h3100, 32'h3104, 0});
    vt.push_back('{0, 0, 0, 0, 3'd7,   32'h3000, 16'h0000, 26'h0, 32'h5000, 32'h0, 32'h3108, 0});
    vt.push_back('{0, 0, 0, 1, OP_B,   32'h3200, 16'h0010, 26'h0, 32'h0, 32'h0, 32'h3244, 0});
    vt.push_back('{0, 0, 0, 0, OP_JR,  32'h3000, 16'h0000, 26'h0, 32'h3000, 32'h0, 32'h3000, 0});

    // T1..T3, T6 address checks: table vectors applied from reset
    do_reset("tbl");
    for (int i = 0; i < vt.size(); i++) begin
      idle();
      req = vt[i].req; eret = vt[i].eret; stall = vt[i].stall; b_jump = vt[i].bj;
      npc_op = vt[i].op; d_pc = vt[i].dpc; imm16 = vt[i].i16; imm26 = vt[i].i26;
      rs = vt[i].rs; epc = vt[i].epc;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/tbl_pc", i), f_pc, vt[i].exp_pc);
      chk($sformatf("vec%0d/tbl_adel", i), {31'd0, f_adel}, {31'd0, vt[i].exp_adel});
    end

    // T4: two calls, a correct return, a mispredicted return
    do_reset("t4");
    ras_push = 1; d_pc = 32'h3000; step("t4push0");
    d_pc = 32'h3100; step("t4push1");
    chk("t4/top2", ras_top, 32'h3108);
    ras_push = 0; ras_pop = 1; npc_op = OP_JR; rs = 32'h3108; step("t4pop0");
    chk("t4/miss0", {26'd0, ras_miss_cnt}, 32'd0);
    chk("t4/top1", ras_top, 32'h3008);
    rs = 32'h3200; step("t4pop1");
    chk("t4/miss1", {26'd0, ras_miss_cnt}, 32'd1);
    chk("t4/empty", {31'd0, ras_valid}, 32'd0);

    // T5: overflow drops the oldest entry, pops on empty count as misses
    do_reset("t5");
    ras_push = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d_pc = 32'h3000 + 32'(i) * 32'h100;
      step($sformatf("t5push%0d", i));
    end
    chk("t5/top_full", ras_top, 32'h3408);
    ras_push = 0; ras_pop = 1; npc_op = OP_JR;
    for (int i = 0; i < DEPTH; i++) begin
      rs = 32'h3408 - 32'(i) * 32'h100;
      step($sformatf("t5pop%0d", i));
    end
    chk("t5/drained", {31'd0, ras_valid}, 32'd0);
    chk("t5/no_miss", {26'd0, ras_miss_cnt}, 32'd0);
    rs = 32'h3008;
    step("t5under0");
    step("t5under1");
    chk("t5/under_miss", {26'd0, ras_miss_cnt}, 32'd2);
    chk("t5/still_empty", {31'd0, ras_valid}, 32'd0);

    // T6: counter saturates
    for (int i = 0; i < 70; i++) step("t6sat");
    chk("t6/saturated", {26'd0, ras_miss_cnt}, MAXC);

    // push+pop in one cycle, on a non-empty and on an empty stack
    do_reset("pp");
    ras_push = 1; ras_pop = 1; npc_op = OP_JR; rs = 32'h3000; d_pc = 32'h3400;
    step("pp_empty");
    chk("pp/empty_push", ras_top, 32'h3408);
    d_pc = 32'h3500; rs = 32'h3408;
    step("pp_full");
    chk("pp/replace", ras_top, 32'h3508);

    // randomized run against the model
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      req      = ($urandom_range(0, 15) == 0);
      eret     = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 7) == 0);
      b_jump   = $urandom_range(0, 1);
      ras_push = ($urandom_range(0, 3) == 0);
      ras_pop  = ($urandom_range(0, 3) == 0);
      npc_op   = 3'($urandom_range(0, 4));
      d_pc     = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      epc      = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      imm16    = 16'($urandom);
      imm26    = 26'($urandom);
      case ($urandom_range(0, 3))
        0:       rs = (m_ras.size() != 0) ? m_ras[$] : 32'($urandom);
        1:       rs = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
        2:       rs = 32'($urandom);
        default: rs = 32'h3000;
      endcase
      step("rnd");
    end

    // asynchronous reset mid-cycle with state present
    idle(); ras_push = 1; d_pc = 32'h3300; step("pre_rst");
    #2;
    reset = 0;
    #1;
    model_reset();
    check_model("mid_rst");
    chk("mid_rst/pc", f_pc, 32'h3000);
    @(negedge clk);
    reset = 1;
    idle();
    step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
